// File: rtl/rv32i_instruction_decode_stage.sv
// RV32I decode stage: one-entry input buffer, combinational decode, registered
// output packet with valid/ready handshake and a RAW-hazard scoreboard.
module rv32i_instruction_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_instruction_latch_en,
    input  logic [31:0] i_fetch_pc,
    input  logic [31:0] i_fetch_instruction,
    output logic        o_decode_ready,
    input  logic        i_branch_miss,
    output logic [4:0]  o_rs1_addr,
    output logic [4:0]  o_rs2_addr,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_rd,
    output logic        o_decode_valid,
    input  logic        i_execute_ready,
    output logic [31:0] o_pc,
    output logic [31:0] o_imm,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    output logic [4:0]  o_rd,
    output logic [2:0]  o_funct3,
    output logic [3:0]  o_alu_op,
    output logic        o_is_load,
    output logic        o_is_store,
    output logic        o_is_branch,
    output logic        o_is_jal,
    output logic        o_is_jalr,
    output logic        o_is_lui,
    output logic        o_is_auipc,
    output logic        o_uses_imm,
    output logic        o_writes_rd,
    output logic        o_illegal
);

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
    } alu_op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic        ib_valid;
    logic [31:0] ib_pc;
    logic [31:0] ib_instr;
    logic        ob_valid;
    logic [31:0] busy;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = ib_instr[6:0];
    assign rd     = ib_instr[11:7];
    assign funct3 = ib_instr[14:12];
    assign rs1    = ib_instr[19:15];
    assign rs2    = ib_instr[24:20];
    assign funct7 = ib_instr[31:25];

    logic [31:0] d_imm;
    alu_op_e     d_alu_op;
    logic d_load, d_store, d_branch, d_jal, d_jalr, d_lui, d_auipc;
    logic d_uses_imm, d_wr, d_writes_rd, d_illegal, use_rs1, use_rs2;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        d_imm = 32'd0;       d_alu_op = ALU_ADD;
        d_load = 1'b0;       d_store = 1'b0;     d_branch = 1'b0;
        d_jal = 1'b0;        d_jalr = 1'b0;      d_lui = 1'b0;      d_auipc = 1'b0;
        d_uses_imm = 1'b0;   d_wr = 1'b0;        d_illegal = 1'b0;
        use_rs1 = 1'b0;      use_rs2 = 1'b0;
        case (opcode)
            OPC_LUI: begin
                d_lui = 1'b1; d_uses_imm = 1'b1; d_wr = 1'b1; d_alu_op = ALU_PASSB;
                d_imm = {ib_instr[31:12], 12'd0};
            end
            OPC_AUIPC: begin
                d_auipc = 1'b1; d_uses_imm = 1'b1; d_wr = 1'b1;
                d_imm = {ib_instr[31:12], 12'd0};
            end
            OPC_JAL: begin
                d_jal = 1'b1; d_uses_imm = 1'b1; d_wr = 1'b1;
                d_imm = {{11{ib_instr[31]}}, ib_instr[31], ib_instr[19:12],
                         ib_instr[20], ib_instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                d_jalr = 1'b1; d_uses_imm = 1'b1; d_wr = 1'b1; use_rs1 = 1'b1;
                d_imm = {{20{ib_instr[31]}}, ib_instr[31:20]};
                d_illegal = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                d_branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                d_imm = {{19{ib_instr[31]}}, ib_instr[31], ib_instr[7],
                         ib_instr[30:25], ib_instr[11:8], 1'b0};
                case (funct3[2:1])
                    2'b00:   d_alu_op = ALU_SUB;
                    2'b10:   d_alu_op = ALU_SLT;
                    2'b11:   d_alu_op = ALU_SLTU;
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                d_load = 1'b1; d_uses_imm = 1'b1; d_wr = 1'b1; use_rs1 = 1'b1;
                d_imm = {{20{ib_instr[31]}}, ib_instr[31:20]};
                d_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                d_store = 1'b1; d_uses_imm = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                d_imm = {{20{ib_instr[31]}}, ib_instr[31:25], ib_instr[11:7]};
                d_illegal = funct3[2] || (funct3 == 3'b011);
            end
            OPC_OPIMM: begin
                d_uses_imm = 1'b1; d_wr = 1'b1; use_rs1 = 1'b1;
                d_imm = {{20{ib_instr[31]}}, ib_instr[31:20]};
                // Only shift-immediates carry a funct7; ADDI's top bits are immediate.
                d_alu_op = alu_from_funct3(funct3, funct7[5] && (funct3 == 3'b101));
                d_illegal = ((funct3 == 3'b001) && (funct7 != 7'h00)) ||
                            ((funct3 == 3'b101) && (funct7 != 7'h00) && (funct7 != 7'h20));
            end
            OPC_OP: begin
                d_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                d_alu_op = alu_from_funct3(funct3, funct7[5]);
                d_illegal = !((funct7 == 7'h00) ||
                              ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            default: d_illegal = 1'b1;
        endcase
        d_writes_rd = d_wr && (rd != 5'd0) && !d_illegal;
    end

    logic rs1_hit, rs2_hit, hazard, accept, issue, transfer;

    // Pending writes are either already in execute (busy) or sitting in the output packet.
    assign rs1_hit  = use_rs1 && (rs1 != 5'd0) &&
                      (busy[rs1] || (ob_valid && o_writes_rd && (o_rd == rs1)));
    assign rs2_hit  = use_rs2 && (rs2 != 5'd0) &&
                      (busy[rs2] || (ob_valid && o_writes_rd && (o_rd == rs2)));
    assign hazard   = rs1_hit || rs2_hit;
    assign accept   = i_instruction_latch_en && !ib_valid && !i_branch_miss;
    assign issue    = ib_valid && !hazard && (!ob_valid || i_execute_ready) && !i_branch_miss;
    assign transfer = ob_valid && i_execute_ready && !i_branch_miss;

    assign o_decode_ready = !ib_valid;
    assign o_decode_valid = ob_valid;
    assign o_rs1_addr     = rs1;
    assign o_rs2_addr     = rs2;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ib_valid <= 1'b0;
            ib_pc    <= 32'd0;
            ib_instr <= 32'd0;
        end else if (i_branch_miss) begin
            ib_valid <= 1'b0;
        end else if (accept) begin
            ib_valid <= 1'b1;
            ib_pc    <= i_fetch_pc;
            ib_instr <= i_fetch_instruction;
        end else if (issue) begin
            ib_valid <= 1'b0;
        end
    end

    // NOTE: the packet fields are plain flops, not a memory, so all of them get a reset value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ob_valid    <= 1'b0;
            o_pc        <= RESET_PC;
            o_imm       <= 32'd0;  o_rs1_data <= 32'd0;  o_rs2_data <= 32'd0;
            o_rd        <= 5'd0;   o_funct3   <= 3'd0;   o_alu_op   <= 4'd0;
            o_is_load   <= 1'b0;   o_is_store <= 1'b0;   o_is_branch <= 1'b0;
            o_is_jal    <= 1'b0;   o_is_jalr  <= 1'b0;   o_is_lui   <= 1'b0;
            o_is_auipc  <= 1'b0;   o_uses_imm <= 1'b0;   o_writes_rd <= 1'b0;
            o_illegal   <= 1'b0;
        end else if (i_branch_miss) begin
            ob_valid <= 1'b0;
        end else if (issue) begin
            ob_valid    <= 1'b1;
            o_pc        <= ib_pc;
            o_imm       <= d_imm;  o_rs1_data <= i_rs1_data;  o_rs2_data <= i_rs2_data;
            o_rd        <= rd;     o_funct3   <= funct3;      o_alu_op   <= d_alu_op;
            o_is_load   <= d_load; o_is_store <= d_store;     o_is_branch <= d_branch;
            o_is_jal    <= d_jal;  o_is_jalr  <= d_jalr;      o_is_lui   <= d_lui;
            o_is_auipc  <= d_auipc; o_uses_imm <= d_uses_imm; o_writes_rd <= d_writes_rd;
            o_illegal   <= d_illegal;
        end else if (transfer) begin
            ob_valid <= 1'b0;
        end
    end

    logic [31:0] busy_set, busy_clr;
    assign busy_set = (transfer && o_writes_rd) ? (32'd1 << o_rd) : 32'd0;
    assign busy_clr = i_wb_valid ? (32'd1 << i_wb_rd) : 32'd0;

    // Set is applied after clear so a same-cycle set/clear of one register stays busy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) busy <= 32'd0;
        else          busy <= ((busy & ~busy_clr) | busy_set) & 32'hFFFF_FFFE;
    end

endmodule
